// File: rtl/memoria_de_dados_parametrizada.sv
// memoria_de_dados_parametrizada: byte-enabled data memory with pipelined reads; define MEMORIA_DADOS_CLEAR_EN for reset-time clearing
module memoria_de_dados_parametrizada #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   datain,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   dataout,
  output logic                    valid,
  output logic                    erro
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int L  = READ_LATENCY;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state_q, state_d;
  logic werr_q, werr_d;
  logic [L-1:0] v_q, v_d, e_q, e_d;
  logic [L-1:0][DATA_WIDTH-1:0] d_q, d_d, d_sh;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic acc, in_range, mem_we;
  logic [CW-1:0] idx, mem_waddr;
  logic [NB-1:0] mem_wbe;
  logic [DATA_WIDTH-1:0] mem_wdata, rd_word;
`ifdef MEMORIA_DADOS_CLEAR_EN
  logic [CW-1:0] cnt_q, cnt_d;
`endif
  assign ready   = state_q == IDLE;
  assign dataout = d_q[L-1];
  assign valid   = v_q[L-1];
  assign erro    = e_q[L-1] | werr_q;
  // accept requests, steer the single write port and advance the read pipeline; stages keep data when empty so dataout holds
  always_comb begin
    acc       = req && ready;
    in_range  = 64'(addr) < 64'(DEPTH);
    idx       = addr[CW-1:0];
    rd_word   = in_range ? mem_q[idx] : '0;
    mem_we    = acc && we && in_range;
    mem_waddr = idx;
    mem_wbe   = be;
    mem_wdata = datain;
    werr_d    = acc && we && !in_range;
    v_d       = L'({v_q, acc && !we});
    e_d       = L'({e_q, acc && !we && !in_range});
    d_sh      = (L*DATA_WIDTH)'({d_q, rd_word});
    for (int i = 0; i < L; i++) d_d[i] = v_d[i] ? d_sh[i] : d_q[i];
`ifdef MEMORIA_DADOS_CLEAR_EN
    cnt_d   = cnt_q;
    state_d = state_q;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wbe   = '1;
      mem_wdata = '0;
      cnt_d     = cnt_q + 1'b1;
      state_d   = cnt_q == CW'(DEPTH - 1) ? IDLE : CLEAR;
    end
`else
    state_d = IDLE;
`endif
  end
  // byte-masked memory write; storage itself is never reset
  always_ff @(posedge clk)
    if (mem_we && !rst)
      for (int i = 0; i < NB; i++)
        if (mem_wbe[i]) mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
  // control state and read pipeline; reset drops all in-flight reads
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= CLEAR;
      werr_q  <= 1'b0;
      v_q     <= '0;
      e_q     <= '0;
      d_q     <= '0;
`ifdef MEMORIA_DADOS_CLEAR_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      werr_q  <= werr_d;
      v_q     <= v_d;
      e_q     <= e_d;
      d_q     <= d_d;
`ifdef MEMORIA_DADOS_CLEAR_EN
      cnt_q   <= cnt_d;
`endif
    end
endmodule

// File: tb/tb_memoria_de_dados_parametrizada.sv
// tb_memoria_de_dados_parametrizada: random and directed checks against a cycle-scheduled reference model
module tb_memoria_de_dados_parametrizada;
  localparam int DW = 32, AW = 32, DEPTH = 1024, LAT = 2;
`ifdef MEMORIA_DADOS_CLEAR_EN
  localparam int CLR = DEPTH;
`else
  localparam int CLR = 1;
`endif
  logic clk = 0, rst = 1, req = 0, we = 0;
  logic [3:0] be = 0;
  logic [AW-1:0] addr = 0;
  logic [DW-1:0] datain = 0;
  logic ready, valid, erro;
  logic [DW-1:0] dataout;

  memoria_de_dados_parametrizada #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .datain(datain),
    .ready(ready), .dataout(dataout), .valid(valid), .erro(erro)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic [31:0] d; logic e;} rsp_t;
  rsp_t q[$];
  logic [31:0] mdl [DEPTH];
  int n = 0, since = 0, werr_due = -1, vectors = 0, miscompares = 0;
  logic rdy_m = 0;
  logic [31:0] last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic cycle();
    logic ev, ee;
    @(posedge clk);
    n++;
    if (rst) begin
      q.delete();
      werr_due = -1;
      last = 0;
      since = 0;
    end else begin
      if (req && rdy_m) begin
        if (we) begin
          if (addr < DEPTH) begin
            for (int i = 0; i < 4; i++) if (be[i]) mdl[addr][8*i +: 8] = datain[8*i +: 8];
          end else werr_due = n;
        end else q.push_back('{n + LAT - 1, addr < DEPTH ? mdl[addr] : 32'h0, addr >= DEPTH});
      end
`ifdef MEMORIA_DADOS_CLEAR_EN
      if (since < CLR) mdl[since] = 32'h0;
`endif
      since++;
    end
    rdy_m = !rst && since >= CLR;
    #1;
    ev = q.size() > 0 && q[0].due == n;
    ee = werr_due == n;
    if (ev) begin
      ee = ee | q[0].e;
      last = q[0].d;
      void'(q.pop_front());
    end
    chk("valid", valid, ev);
    chk("dataout", dataout, last);
    chk("erro", erro, ee);
    chk("ready", ready, rdy_m);
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    req = r; we = w; be = b; addr = a; datain = d;
    cycle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(1'b1, 1'b1, b, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b1, 1'b0, 4'h0, a, 32'h0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (!ready && c < 3000) begin idle(); c++; end
    chk("ready_timeout", ready, 1);
  endtask

  initial begin
    int c;
    rst = 1;
    idle();
    idle();
    chk("rst_ready", ready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_dataout", dataout, 0);
    rst = 0;
`ifdef MEMORIA_DADOS_CLEAR_EN
    repeat (500) idle();
    rst = 1;
    idle();
    rst = 0;
    c = 0;
    while (!ready && c < 3000) begin idle(); c++; end
    chk("clear_len", c, DEPTH);
    rd(0);
    rd(1023);
    chk("clear_w0", dataout, 0);
    chk("clear_w0_v", valid, 1);
    idle();
    chk("clear_w1023", dataout, 0);
    chk("clear_w1023_v", valid, 1);
`else
    idle();
    chk("ready_after_rst", ready, 1);
`endif
    for (int a = 0; a < DEPTH; a++) wr(a, $urandom, 4'hf);
    wr(5, 32'hDEADBEEF, 4'hf);
    rd(5);
    idle();
    chk("w5_valid", valid, 1);
    chk("w5_data", dataout, 32'hDEADBEEF);
    chk("w5_erro", erro, 0);
    wr(7, 32'h11223344, 4'hf);
    wr(7, 32'hAABBCCDD, 4'b0101);
    rd(7);
    idle();
    chk("be_merge", dataout, 32'h11BB33DD);
    wr(1, 32'hA, 4'hf);
    wr(2, 32'hB, 4'hf);
    wr(3, 32'hC, 4'hf);
    rd(1);
    rd(2);
    chk("b2b_0", dataout, 32'hA);
    rd(3);
    chk("b2b_1", dataout, 32'hB);
    chk("b2b_1v", valid, 1);
    idle();
    chk("b2b_2", dataout, 32'hC);
    chk("b2b_2v", valid, 1);
    idle();
    wr(1024, 32'h55555555, 4'hf);
    chk("oor_werr", erro, 1);
    idle();
    chk("oor_werr_end", erro, 0);
    rd(0);
    rd(2000);
    idle();
    chk("oor_rd_v", valid, 1);
    chk("oor_rd_d", dataout, 0);
    chk("oor_rd_e", erro, 1);
    idle();
    for (int k = 0; k < 3000; k++) begin
      rst = $urandom_range(0, 299) == 0;
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 1100)), $urandom);
    end
    rst = 0;
    wait_ready();
    rd(1);
    req = 1; we = 0; addr = 2; rst = 1;
    cycle();
    chk("rst_flight_v", valid, 0);
    chk("rst_flight_d", dataout, 0);
    rst = 0;
    idle();
    chk("rst_flight_v1", valid, 0);
    idle();
    chk("rst_flight_v2", valid, 0);
    repeat (4) idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
